// File: rtl/formula_pkg.sv
// formula_pkg: shared widths and pipeline timing for the formula datapath
package formula_pkg;
  localparam int FLEN = 64;
  localparam int PIPE_LATENCY = 6;
  localparam int DEPTH_DEFAULT = PIPE_LATENCY + 2;
endpackage

// File: rtl/flip_flop_fifo_with_counter.sv
// flip_flop_fifo_with_counter: register-based FIFO with occupancy count, wrapping pointers and saturating count
module flip_flop_fifo_with_counter #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_empty,
  output logic             o_full
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count, w_count_nxt;
  assign o_empty = r_count == '0;
  assign o_full = r_count == CW'(DEPTH);
  assign o_data = r_mem[r_rptr];
  assign o_count = r_count;
  // Illegal over/underflow still moves the pointers; only the count saturates.
  always_comb w_count_nxt = (i_push & ~i_pop & ~o_full) ? r_count + CW'(1) :
                            (i_pop & ~i_push & ~o_empty) ? r_count - CW'(1) : r_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
      if (i_pop) r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end
  always_ff @(posedge clk) if (i_push) r_mem[r_wptr] <= i_data;
endmodule

// File: rtl/formula_credit_result_buffer.sv
// formula_credit_result_buffer: credit-based arg_rdy for a non-stallable pipeline,
// with a FIFO that captures every result and presents it as a valid/ready stream
module formula_credit_result_buffer
  import formula_pkg::*;
#(
  parameter int width = FLEN,
  parameter int depth = DEPTH_DEFAULT,
  parameter bit allow_accept_on_pop = 1'b0,
  localparam int CW = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic             in_vld,
  input  logic [width-1:0] in_data,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [width-1:0] res,
  output logic             error
);
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_fcnt;
  logic r_error, w_full, w_empty, w_accept, w_pop, w_err_evt;
  flip_flop_fifo_with_counter #(.WIDTH(width), .DEPTH(depth)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(in_vld),
    .i_pop(w_pop),
    .i_data(in_data),
    .o_data(res),
    .o_count(w_fcnt),
    .o_empty(w_empty),
    .o_full(w_full)
  );
  assign res_vld = ~w_empty;
  assign w_pop = res_vld & res_rdy;
  assign arg_rdy = ~rst & ((r_cnt != CW'(depth)) | (allow_accept_on_pop & w_pop));
  assign w_accept = arg_vld & arg_rdy;
  assign error = r_error;
  always_comb w_cnt_nxt = (w_accept & ~w_pop & (r_cnt != CW'(depth))) ? r_cnt + CW'(1) :
                          (w_pop & ~w_accept & (r_cnt != '0)) ? r_cnt - CW'(1) : r_cnt;
  // cnt == fcnt means nothing is still in flight inside the pipeline.
  always_comb w_err_evt = (in_vld & (r_cnt == w_fcnt)) | (in_vld & w_full & ~w_pop) | (w_pop & w_empty);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_error <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_error <= r_error | w_err_evt;
    end
  end
endmodule
